tt_proj_mux_wrapper: RTL

- Parametrised successor to the single-project pad wrappers: one wrapper serves N_PROJ project slots sharing one pad bundle.
- Selects one active project at a time through a valid/ready request.
- On every switch it inserts a guard interval (all ena low, outputs tristated), then a clean reset pulse to the new project, before handing it the pads.
- Sits between the chip pad ring (iw/ow bundles) and the per-project wrappers.

---
 rtl/tt_mux_pkg.sv | 11 +
 rtl/tt_proj_mux_wrapper_if.sv | 10 +
 rtl/tt_proj_mux_seq.sv | 70 +++++++
 rtl/tt_proj_mux_wrapper.sv | 71 +++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: sequencer state encoding and pad-bundle field positions shared by the project mux
package tt_mux_pkg;
  typedef enum logic [1:0] {IDLE, GUARD, RSTP, ACTIVE} state_e;
  localparam int IW_CLK     = 0;
  localparam int IW_RSTN    = 1;
  localparam int IW_UI_LSB  = 2;
  localparam int IW_UIO_LSB = 10;
  localparam int OW_UO_LSB  = 0;
  localparam int OW_UIO_LSB = 8;
  localparam int OW_OE_LSB  = 16;
endpackage

// File: rtl/tt_proj_mux_wrapper_if.sv
// tt_proj_mux_wrapper_if: slot-select valid/ready handshake
interface tt_proj_mux_wrapper_if #(
  parameter int SEL_W = 3
);
  logic             sel_valid;
  logic [SEL_W-1:0] sel_idx;
  logic             sel_ready;
  modport master (output sel_valid, sel_idx, input sel_ready);
  modport slave  (input sel_valid, sel_idx, output sel_ready);
endinterface

// File: rtl/tt_proj_mux_seq.sv
// tt_proj_mux_seq: select FSM walking IDLE -> GUARD -> RSTP -> ACTIVE with one shared down-counter
module tt_proj_mux_seq
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ    = 4,
  parameter int GUARD_CYC = 4,
  parameter int RST_CYC   = 8,
  parameter int SEL_W     = $clog2(N_PROJ) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid_i,
  input  logic [SEL_W-1:0] sel_idx_i,
  output logic             sel_ready_o,
  output state_e           state_o,
  output state_e           state_d_o,
  output logic [SEL_W-1:0] target_o,
  output logic [SEL_W-1:0] target_d_o
);
  localparam int CNT_MAX = GUARD_CYC > RST_CYC ? GUARD_CYC : RST_CYC;
  localparam int CNT_W = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
  localparam logic [SEL_W-1:0] NONE = '1;
  state_e           state_q, state_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, idx_ok, done;
  assign sel_ready_o = state_q == IDLE || state_q == ACTIVE;
  assign accept      = sel_valid_i && sel_ready_o;
  assign idx_ok      = sel_idx_i < SEL_W'(N_PROJ);
  assign done        = cnt_q == '0;
  // counter holds cycles remaining in the current timed state, reloaded on entry
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = done ? cnt_q : cnt_q - 1'b1;
    unique case (state_q)
      IDLE: if (accept && idx_ok) begin
        state_d  = GUARD;
        target_d = sel_idx_i;
        cnt_d    = CNT_W'(GUARD_CYC - 1);
      end
      ACTIVE: if (accept) begin
        state_d  = GUARD;
        target_d = idx_ok ? sel_idx_i : NONE;
        cnt_d    = CNT_W'(GUARD_CYC - 1);
      end
      GUARD: if (done) begin
        state_d = target_q < SEL_W'(N_PROJ) ? RSTP : IDLE;
        cnt_d   = CNT_W'(RST_CYC - 1);
      end
      RSTP: if (done) state_d = ACTIVE;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end
  assign state_o    = state_q;
  assign state_d_o  = state_d;
  assign target_o   = target_q;
  assign target_d_o = target_d;
endmodule

// File: rtl/tt_proj_mux_wrapper.sv
// tt_proj_mux_wrapper: shares one pad bundle among N_PROJ project slots with a guard gap
// and a clean reset pulse inserted on every switch.
module tt_proj_mux_wrapper
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ    = 4,
  parameter int IW_W      = 18,
  parameter int OW_W      = 24,
  parameter int GUARD_CYC = 4,
  parameter int RST_CYC   = 8,
  parameter int SEL_W     = $clog2(N_PROJ) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  tt_proj_mux_wrapper_if.slave   sel,
  input  logic [IW_W-1:0]        pad_iw,
  output logic [OW_W-1:0]        pad_ow,
  output logic [N_PROJ-1:0]      proj_ena,
  output logic [IW_W-1:0]        proj_iw,
  input  logic [N_PROJ*OW_W-1:0] proj_ow,
  output logic                   active,
  output logic [SEL_W-1:0]       active_idx
);
  state_e                state_q, state_d;
  logic [SEL_W-1:0]      target_q, target_d;
  logic [OW_W-1:0]       slot_ow, pad_ow_q, pad_ow_d;
  logic [N_PROJ-1:0]     proj_ena_q, proj_ena_d;
  logic                  active_q, active_d;
  tt_proj_mux_seq #(
    .N_PROJ(N_PROJ), .GUARD_CYC(GUARD_CYC), .RST_CYC(RST_CYC), .SEL_W(SEL_W)
  ) u_seq (
    .clk(clk),
    .rst(rst),
    .sel_valid_i(sel.sel_valid),
    .sel_idx_i(sel.sel_idx),
    .sel_ready_o(sel.sel_ready),
    .state_o(state_q),
    .state_d_o(state_d),
    .target_o(target_q),
    .target_d_o(target_d)
  );
  always_comb begin
    slot_ow = '0;
    for (int k = 0; k < N_PROJ; k++)
      slot_ow = target_q == SEL_W'(k) ? proj_ow[k*OW_W +: OW_W] : slot_ow;
  end
  // pads only carry slot data while ACTIVE both before and after the edge, so the
  // first ACTIVE cycle and the first cycle after a switch request both read 0
  assign pad_ow_d   = state_q == ACTIVE && state_d == ACTIVE ? slot_ow : '0;
  assign proj_ena_d = state_d == RSTP || state_d == ACTIVE ? N_PROJ'(1) << target_d : '0;
  assign active_d   = state_d == ACTIVE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_ow_q   <= '0;
      proj_ena_q <= '0;
      active_q   <= 1'b0;
    end else begin
      pad_ow_q   <= pad_ow_d;
      proj_ena_q <= proj_ena_d;
      active_q   <= active_d;
    end
  end
  always_comb begin
    proj_iw          = pad_iw;
    proj_iw[IW_RSTN] = pad_iw[IW_RSTN] && state_q != RSTP;
  end
  assign pad_ow     = pad_ow_q;
  assign proj_ena   = proj_ena_q;
  assign active     = active_q;
  assign active_idx = target_q;
endmodule
